// File: rtl/gd_pkg.sv
// Shared constants and types for the scrolling obstacle-map path.
//   TILE_LOG2 : log2 of the tile width in pixels (32-pixel tiles)
//   DEPTH     : ring-buffer entries, power of two
//   VACTIVE   : first non-visible line; pending scroll is applied here
//   obstacle_id_t / OBST_AIR : 8-bit obstacle id, 0 means empty sky
package gd_pkg;

  localparam int TILE_LOG2 = 5;
  localparam int DEPTH     = 32;
  localparam int VACTIVE   = 480;

  typedef logic [7:0] obstacle_id_t;

  localparam obstacle_id_t OBST_AIR = 8'h00;

endpackage

// File: rtl/map_ring_ram.sv
// DEPTH x 8 simple dual-port RAM with a registered read port.
//   clk      : clock
//   wr_en    : write strobe for wr_addr/wr_data
//   wr_addr  : write address
//   wr_data  : obstacle id to store
//   rd_addr  : read address, sampled every clock
//   rd_data  : data at rd_addr one clock later (old data on a same-entry write)
// No reset on the array or the read register so it maps onto block RAM.
module map_ring_ram
  import gd_pkg::*;
(
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  obstacle_id_t             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output obstacle_id_t             rd_data
);

  obstacle_id_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Separate process from the write: read-before-write returns the old word.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/map_block_buffer.sv
// Scrolling obstacle-map ring buffer feeding the VGA renderer.
//   clk, reset_n   : clock, asynchronous active-low reset
//   clear          : synchronous flush of buffer, scroll and read pipeline
//   wr_en, wr_data : push one obstacle id at the tail
//   scroll_step    : request a 1-pixel scroll, applied at vblank entry
//   hcount, vcount : raster position; pixel column is hcount[10:1]
//   tile_id        : obstacle id for the pixel presented 2 clocks earlier
//   tile_px        : x offset of that pixel inside its tile
//   count/full/empty : occupancy (registered)
//   overflow       : sticky, a push was dropped because the buffer was full
//   underrun       : sticky, a tile retire found the buffer empty
module map_block_buffer
  import gd_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [7:0]           wr_data,
  input  logic                 scroll_step,
  input  logic [10:0]          hcount,
  input  logic [9:0]           vcount,
  output logic [7:0]           tile_id,
  output logic [TILE_LOG2-1:0] tile_px,
  output logic [5:0]           count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = 11 - TILE_LOG2;

  logic [AW-1:0]        head_reg, tail_reg;
  logic [CW-1:0]        count_reg, count_next;
  logic [TILE_LOG2-1:0] fine_x_reg;
  logic                 pending_reg;
  logic                 overflow_reg, underrun_reg;

  logic [AW-1:0]        s1_addr_reg;
  logic                 s1_valid_reg;
  logic [TILE_LOG2-1:0] s1_px_reg;
  logic                 s2_valid_reg;
  logic [TILE_LOG2-1:0] s2_px_reg;

  logic                 full_w, empty_w;
  logic                 apply_w, wrap_w, retire_ok, retire_empty, push_ok;
  logic [10:0]          pos_w;
  logic [OW-1:0]        off_w;
  obstacle_id_t         ram_q;
  logic                 unused_hcount_lsb;

  assign unused_hcount_lsb = hcount[0];

  assign full_w  = (count_reg == CW'(DEPTH));
  assign empty_w = (count_reg == '0);

  // Scroll is applied on the single vblank-entry cycle; a full tile of
  // scroll retires the head entry.
  assign apply_w      = pending_reg && (vcount == 10'(VACTIVE)) && (hcount == '0);
  assign wrap_w       = apply_w && (fine_x_reg == '1);
  assign retire_ok    = wrap_w && !empty_w;
  assign retire_empty = wrap_w && empty_w;
  // Fullness is judged before the retire, so a retire frees room this cycle.
  assign push_ok      = wr_en && (!full_w || retire_ok);

  always_comb begin
    count_next = count_reg;
    case ({push_ok, retire_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Stage 0: screen column plus fine scroll gives the map pixel position.
  assign pos_w = {1'b0, hcount[10:1]} + 11'(fine_x_reg);
  assign off_w = pos_w[10:TILE_LOG2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      fine_x_reg   <= '0;
      pending_reg  <= 1'b0;
      overflow_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else if (clear) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      fine_x_reg   <= '0;
      pending_reg  <= 1'b0;
      overflow_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        tail_reg <= tail_reg + AW'(1);
      end
      if (wr_en && !push_ok) begin
        overflow_reg <= 1'b1;
      end
      if (retire_ok) begin
        head_reg <= head_reg + AW'(1);
      end
      if (retire_empty) begin
        underrun_reg <= 1'b1;
      end
      if (apply_w) begin
        fine_x_reg <= fine_x_reg + TILE_LOG2'(1);
      end
      count_reg <= count_next;
      // A request landing on the apply cycle is kept for the next frame.
      if (scroll_step) begin
        pending_reg <= 1'b1;
      end else if (apply_w) begin
        pending_reg <= 1'b0;
      end
    end
  end

  // Stages 1 and 2 of the read pipeline; the RAM read register is stage 2's data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_addr_reg  <= '0;
      s1_valid_reg <= 1'b0;
      s1_px_reg    <= '0;
      s2_valid_reg <= 1'b0;
      s2_px_reg    <= '0;
    end else if (clear) begin
      s1_addr_reg  <= '0;
      s1_valid_reg <= 1'b0;
      s1_px_reg    <= '0;
      s2_valid_reg <= 1'b0;
      s2_px_reg    <= '0;
    end else begin
      s1_addr_reg  <= head_reg + off_w[AW-1:0];
      s1_valid_reg <= (OW'(off_w) < OW'(count_reg));
      s1_px_reg    <= pos_w[TILE_LOG2-1:0];
      s2_valid_reg <= s1_valid_reg;
      s2_px_reg    <= s1_px_reg;
    end
  end

  map_ring_ram u_ram (
    .clk     (clk),
    .wr_en   (push_ok && !clear),
    .wr_addr (tail_reg),
    .wr_data (wr_data),
    .rd_addr (s1_addr_reg),
    .rd_data (ram_q)
  );

  // The RAM word is not reset; the valid bit masks it to air after reset/clear.
  assign tile_id  = s2_valid_reg ? ram_q : OBST_AIR;
  assign tile_px  = s2_px_reg;
  assign count    = count_reg;
  assign full     = full_w;
  assign empty    = empty_w;
  assign overflow = overflow_reg;
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_map_block_buffer.sv
module tb_map_block_buffer;
  import gd_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        scroll_step = 1'b0;
  logic [10:0] hcount = 11'd0;
  logic [9:0]  vcount = 10'd0;
  logic [7:0]  tile_id;
  logic [4:0]  tile_px;
  logic [5:0]  count;
  logic        full, empty, overflow, underrun;

  always #5 clk = ~clk;

  map_block_buffer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .scroll_step (scroll_step),
    .hcount      (hcount),
    .vcount      (vcount),
    .tile_id     (tile_id),
    .tile_px     (tile_px),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .underrun    (underrun)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: the map is a circular list of ids; a read looks up the
  // tile (pixel + scroll) / 32 positions past the head.
  logic [7:0] m_mem [32];
  int         m_head, m_count, m_fine;
  bit         m_pend, m_ovf, m_und;
  bit         s1_v;
  int         s1_idx, s1_px;
  logic [7:0] e_id;
  int         e_px;

  task automatic model_reset();
    m_head = 0; m_count = 0; m_fine = 0;
    m_pend = 0; m_ovf = 0; m_und = 0;
    s1_v = 0; s1_idx = 0; s1_px = 0;
    e_id = 8'h00; e_px = 0;
  endtask

  task automatic model_clock();
    int  pos, off, nc;
    bit  apply, retiring, was_full;
    // Output shows the lookup decided one cycle ago, against memory as it is now.
    e_id = s1_v ? m_mem[s1_idx] : 8'h00;
    e_px = s1_px;
    if (clear) begin
      model_reset();
      return;
    end
    pos    = int'(hcount) / 2 + m_fine;
    off    = pos / 32;
    s1_v   = off < m_count;
    s1_idx = (m_head + off) % 32;
    s1_px  = pos % 32;
    apply    = m_pend && vcount == 10'd480 && hcount == 11'd0;
    retiring = apply && m_fine == 31 && m_count > 0;
    was_full = m_count == 32;
    nc = m_count;
    if (wr_en) begin
      if (!was_full || retiring) begin
        m_mem[(m_head + m_count) % 32] = wr_data;
        nc++;
      end else begin
        m_ovf = 1;
      end
    end
    if (apply) begin
      if (m_fine < 31) m_fine++;
      else begin
        m_fine = 0;
        if (m_count == 0) m_und = 1;
        else begin
          m_head = (m_head + 1) % 32;
          nc--;
        end
      end
    end
    m_count = nc;
    if (scroll_step) m_pend = 1;
    else if (apply) m_pend = 0;
  endtask

  initial begin : model_proc
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_clock();
    end
  end

  initial begin : compare_proc
    int act, exp;
    forever begin
      @(negedge clk);
      exp = {e_id, 5'(e_px), 6'(m_count), m_count == 32, m_count == 0, m_ovf, m_und};
      act = {tile_id, tile_px, count, full, empty, overflow, underrun};
      check("cycle {id,px,count,full,empty,ovf,und}", act, exp);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic read_px(input int pixel);
    hcount = 11'(pixel * 2);
    step(); step();
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      scroll_step = 1'b1;
      step();
      scroll_step = 1'b0;
    end
  endtask

  task automatic apply_frame(input bit w, input logic [7:0] d);
    logic [10:0] h;
    h = hcount;
    vcount = 10'd480; hcount = 11'd0;
    wr_en = w; wr_data = d;
    step();
    wr_en = 1'b0; vcount = 10'd0; hcount = h;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      pulse(1);
      apply_frame(0, 8'h00);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin : stimulus
    step(); step();
    reset_n = 1'b1;
    step();
    check("reset count", count, 0);
    check("reset empty", empty, 1);
    check("reset full", full, 0);
    check("reset tile_id", tile_id, 0);

    push(8'h11); push(8'h22); push(8'h33);
    check("push3 count", count, 3);
    check("push3 empty", empty, 0);
    read_px(0);
    check("pix0 id", tile_id, 8'h11);
    check("pix0 px", tile_px, 0);
    read_px(64);
    check("pix64 id", tile_id, 8'h33);
    read_px(96);
    check("pix96 air", tile_id, 8'h00);

    // Three requests in one frame collapse into one step, visible only after vblank.
    read_px(0);
    pulse(3);
    step();
    check("pre-apply px", tile_px, 0);
    apply_frame(0, 8'h00);
    step(); step();
    check("after 1 step px", tile_px, 1);
    frames(4);
    step(); step();
    check("fine5 px", tile_px, 5);
    check("fine5 id", tile_id, 8'h11);
    read_px(27);
    check("pix27 id", tile_id, 8'h22);
    check("pix27 px", tile_px, 0);

    frames(26);
    read_px(0);
    check("fine31 px", tile_px, 31);
    frames(1);
    read_px(0);
    check("retire id", tile_id, 8'h22);
    check("retire px", tile_px, 0);
    check("retire count", count, 2);

    do_clear();
    check("clear count", count, 0);
    for (int i = 0; i < 32; i++) push(8'(8'h40 + i));
    check("fill count", count, 32);
    check("fill full", full, 1);
    check("fill overflow", overflow, 0);
    frames(31);
    pulse(1);
    apply_frame(1, 8'h77);
    check("push+retire count", count, 32);
    check("push+retire overflow", overflow, 0);
    read_px(0);
    check("after retire head", tile_id, 8'h41);
    read_px(992);
    check("last tile", tile_id, 8'h77);
    push(8'h60);
    check("drop overflow", overflow, 1);
    check("drop count", count, 32);
    read_px(992);
    check("dropped id absent", tile_id, 8'h77);

    do_clear();
    check("clear overflow", overflow, 0);
    frames(32);
    check("underrun flag", underrun, 1);
    check("underrun count", count, 0);
    check("underrun empty", empty, 1);

    do_clear();
    for (int i = 0; i < 10; i++) push(8'(8'h80 + i));
    frames(7);
    read_px(0);
    check("fine7 px", tile_px, 7);
    check("fine7 id", tile_id, 8'h80);
    do_clear();
    check("midclear count", count, 0);
    check("midclear underrun", underrun, 0);
    check("midclear px", tile_px, 0);
    check("midclear id", tile_id, 0);
    step(); step();
    check("clear+2 id", tile_id, 0);

    push(8'hAB);
    read_px(0);
    check("pre-reset id", tile_id, 8'hAB);
    #2 reset_n = 1'b0;
    #1;
    check("async reset id", tile_id, 0);
    check("async reset count", count, 0);
    check("async reset empty", empty, 1);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post reset count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/map_block_buffer.md
Name: map_block_buffer

Overview:
- Scrolling obstacle-map store that feeds the VGA sprite/background renderer.
- Software pushes 8-bit obstacle ids, one per map column tile, into a ring buffer.
- The renderer presents the raster position each clock; the block returns the obstacle id and in-tile x offset for that pixel, 2 cycles later.
- Horizontal scroll advances a fine pixel offset; fully scrolled-off tiles are retired. Scroll updates take effect only at vblank entry, so no frame tears.

Parameters:
- DEPTH, 32, ring-buffer entries (power of two).
- TILE_LOG2, 5, log2 of tile width in pixels (32-pixel tiles).
- VACTIVE, 480, first non-visible line; scroll is applied here.

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of buffer and scroll state
- wr_en  in  1  push request (one register write)
- wr_data  in  8  obstacle id to push
- scroll_step  in  1  pulse: request a 1-pixel scroll
- hcount  in  11  raster counter; pixel column = hcount[10:1]
- vcount  in  10  raster line
- tile_id  out  8  obstacle id for the pixel presented 2 cycles earlier (0 = air)
- tile_px  out  5  x offset of that pixel within its tile
- count  out  6  occupied entries (0..DEPTH)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: a push was dropped
- underrun  out  1  sticky: a retire was attempted on an empty buffer

Behaviour:
- Reset (async, reset_n low) clears head, tail, count, fine_x, scroll_pending, tile_id, tile_px, overflow and underrun to 0. The memory contents are don't-care.
- clear has the same effect synchronously and has priority over every other input in that cycle.
- Push:
  - When wr_en and not full: mem[tail] <= wr_data, tail <= tail+1 (wraps mod DEPTH), count+1.
  - When wr_en and full: the data is dropped, overflow <= 1, and state is otherwise unchanged.
- Scroll request: a scroll_step pulse sets scroll_pending. Multiple pulses within one frame collapse into a single step.
- Scroll apply:
  - Fires in the cycle where vcount == VACTIVE and hcount == 0 and scroll_pending is set. That cycle clears scroll_pending.
  - If fine_x < 2^TILE_LOG2-1: fine_x+1.
  - Otherwise fine_x <= 0 and the head tile is retired: head+1, count-1.
  - If count == 0 at retire: head and count are unchanged, underrun <= 1, and fine_x still wraps to 0.
- Simultaneous push and retire: both pointers advance and count is unchanged. A push is accepted when full in the same cycle as a retire (full is evaluated before the retire).
- A scroll_step arriving in the apply cycle sets scroll_pending for the next frame.
- Read pipeline:
  - Stage 0 (combinational): pos = {1'b0, hcount[10:1]} + fine_x (11 bits, no overflow); off = pos >> TILE_LOG2; px = pos[TILE_LOG2-1:0].
  - Stage 1 (registered): addr = (head + off) mod DEPTH, valid = (off < count), px.
  - Stage 2 (registered): tile_id = valid ? mem[addr] : 0; tile_px = px.
  - Latency is exactly 2 clk. Reads run every cycle, including during blanking.
  - A read in the same cycle as a write to the same entry returns the old data.
- Output timing: count, full and empty are registered state, not lookahead.

Decomposition:
- Shared package gd_pkg holds:
  - TILE_LOG2, DEPTH, VACTIVE;
  - typedef obstacle_id_t (logic [7:0]);
  - constant OBST_AIR = 8'h00.
- One natural sub-module: map_ring_ram, a DEPTH x 8 simple dual-port RAM with synchronous read (one write port, one read port), so it can infer M10K.
- The pointer, count and scroll logic stays in the top module.

Test Plan:
- Reset/push: release reset_n; push 0x11, 0x22, 0x33 -> count=3, empty=0. Present hcount=0 -> tile_id=0x11, tile_px=0 after 2 clk. hcount=128 (pixel 64) -> 0x33. Pixel 96 -> 0x00 (air).
- Full/overflow: push 33 ids -> count=32, full=1, overflow=1; the 33rd id is never returned by any read.
- Scroll within tile: 1 scroll_step per frame for 5 frames -> fine_x=5. Pixel 0 -> tile_px=5, tile_id=head id. Pixel 27 -> next tile, tile_px=0. Changes appear only after the vcount=480, hcount=0 cycle.
- Retire: with count=3 and fine_x=31, one more step -> fine_x=0, count=2. Pixel 0 now returns 0x22.
- Underrun/simultaneity: with count=0, retire -> underrun=1, count=0. With full, a push and retire in the same cycle -> count stays 32 and overflow stays unchanged.
- Mid-operation reset/clear: assert clear with count=10 and fine_x=7 -> next cycle all state is 0 and tile_id=0 two cycles later. Pulse reset_n low asynchronously mid-line -> outputs go to 0 immediately.
